sensor_acquire: RTL and testbench
=================================

Name: sensor_acquire

Overview:
- Upstream acquisition stage for the baggage-drop datapath.
- Sequentially polls the four height sensors over one shared, multiplexed sensor bus, with settle time and a per-sensor timeout.
- Applies the faulty-sensor (zero reading) averaging rule and presents one 8-bit height with a valid/ready handshake.
- Its height output feeds the square-root stage directly.

Parameters:
- SETTLE_CYCLES, 3: cycles sensor_sel is held before sensor_rdy is considered (≥1).
- TIMEOUT_CYCLES, 8: cycles spent in WAIT without sensor_rdy before the reading is forced to 0 (≥1).

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst, input, 1: asynchronous active-high reset.
- sample_req, input, 1: start an acquisition; sampled only in IDLE.
- sensor_sel, output, 2: index of the sensor currently addressed (0..3 = sensor1..sensor4).
- sensor_data, input, 8: reading of the addressed sensor.
- sensor_rdy, input, 1: sensor_data is valid this cycle.
- busy, output, 1: high in every state except IDLE.
- height, output, 8: computed height, stable while height_valid is high.
- height_valid, output, 1: result available.
- height_ready, input, 1: consumer accepts the result.
- fault, output, 1: both sensor pairs contain a zero reading; height forced to 0.
- timeout_mask, output, 4: bit k set if sensor k+1 timed out in the last acquisition.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; idx, counters and the four capture registers go to 0. All outputs are 0: sensor_sel, busy, height, height_valid, fault, timeout_mask.
- States: IDLE, SETTLE, WAIT, COMPUTE, DONE.
- IDLE:
  - sample_req=1 at an edge → SETTLE with idx=0 and cnt=0.
  - On the same edge, timeout_mask and fault clear; height keeps its old value.
- SETTLE:
  - sensor_sel=idx throughout.
  - Stays SETTLE_CYCLES cycles, then → WAIT with cnt=0.
  - sensor_rdy is ignored here.
- WAIT:
  - If sensor_rdy=1 at an edge: reg[idx] ← sensor_data.
  - Else cnt increments. When cnt reaches TIMEOUT_CYCLES without rdy: reg[idx] ← 0 and timeout_mask[idx] ← 1.
  - After a capture: idx==3 → COMPUTE; otherwise idx+1 → SETTLE.
  - sensor_rdy arriving on the same edge the timeout would fire wins: data is captured and no timeout bit is set.
- COMPUTE: one cycle. height and fault are registered. The s1..s4 values below are the capture registers.
  - Pair A is (s1,s3); pair B is (s2,s4).
  - Both pairs contain a 0: fault=1, height=0.
  - Only pair A contains a 0: height=(s2+s4+1)>>1, using a 9-bit sum.
  - Only pair B contains a 0: height=(s1+s3+1)>>1.
  - No zeros: height=(s1+s2+s3+s4+2)>>2, using a 10-bit sum.
  - Result always fits in 8 bits; no saturation is needed.
- DONE:
  - height_valid=1 until an edge where height_ready=1; then → IDLE with height_valid=0 on that edge.
  - height, fault and timeout_mask are held while valid.
- sample_req outside IDLE is ignored and not queued, including the DONE handshake cycle.
- height_ready outside DONE is ignored.
- busy is high in every state except IDLE.
- Latency, with sensor_rdy already high on entry to WAIT:
  - Sensor k's SETTLE starts after edge k·(SETTLE_CYCLES+1), counting from the edge that samples sample_req as edge 0.
  - COMPUTE follows edge 4·(SETTLE_CYCLES+1).
  - height_valid rises after edge 4·(SETTLE_CYCLES+1)+1, i.e. edge 17 at the defaults.
- Each timeout adds TIMEOUT_CYCLES-1 cycles relative to an immediate rdy.

Test Plan:
- Nominal: readings 100,102,98,104, sensor_rdy held 1, sample_req pulse → sensor_sel steps 0,1,2,3 for 4 cycles each; height_valid rises on edge 17; height=101, fault=0, timeout_mask=0.
- Zero in pair A: readings 0,50,90,51 → height=51 ((50+51+1)>>1), fault=0. Zero in pair B: readings 40,0,41,200 → height=41.
- Double fault: readings 0,0,30,30 → height=0, fault=1. Timeout: sensor 3 never asserts rdy, others 60 → timeout_mask=4'b0100, sensor 3 captured as 0, height=60 (average of s2 and s4), valid delayed by 7 cycles vs nominal (TIMEOUT_CYCLES-1).
- Handshake: height_ready held 0 for 10 cycles after valid → height, height_valid and timeout_mask stable; sample_req pulsed during DONE is ignored. Raising height_ready drops valid next edge and returns to IDLE; a later sample_req starts a new run.
- Reset mid-operation: assert rst asynchronously during WAIT of sensor 2 (between clock edges) → all outputs 0 immediately; after release, a full nominal run gives height=101 again.
- Race: sensor_rdy rises exactly on the timeout edge → data captured, timeout_mask bit clear.

Source files
------------

// File: rtl/sensor_acquire.sv
// Polls four height sensors over a shared bus (settle + per-sensor timeout),
// applies the zero-reading pair rule and presents an 8-bit height with valid/ready.
module sensor_acquire #(
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_req,
  output logic [1:0] sensor_sel,
  input  logic [7:0] sensor_data,
  input  logic       sensor_rdy,
  output logic       busy,
  output logic [7:0] height,
  output logic       height_valid,
  input  logic       height_ready,
  output logic       fault,
  output logic [3:0] timeout_mask
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    WAIT    = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0][7:0]  cap;

  logic       zero_a;
  logic       zero_b;
  logic [8:0] sum_a;
  logic [8:0] sum_b;
  logic [9:0] sum_all;
  logic [7:0] height_next;
  logic       fault_next;

  // Pair A = (s1,s3) = cap[0],cap[2]; pair B = (s2,s4) = cap[1],cap[3]
  always_comb begin
    zero_a      = (cap[0] == 8'd0) || (cap[2] == 8'd0);
    zero_b      = (cap[1] == 8'd0) || (cap[3] == 8'd0);
    sum_a       = 9'(cap[0]) + 9'(cap[2]) + 9'd1;
    sum_b       = 9'(cap[1]) + 9'(cap[3]) + 9'd1;
    sum_all     = 10'(cap[0]) + 10'(cap[1]) + 10'(cap[2]) + 10'(cap[3]) + 10'd2;
    fault_next  = 1'b0;
    height_next = sum_all[9:2];
    if (zero_a && zero_b) begin
      fault_next  = 1'b1;
      height_next = 8'd0;
    end else if (zero_a) begin
      height_next = sum_b[8:1];
    end else if (zero_b) begin
      height_next = sum_a[8:1];
    end
  end

  assign sensor_sel = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 2'd0;
      cnt          <= '0;
      cap          <= '0;
      busy         <= 1'b0;
      height       <= 8'd0;
      height_valid <= 1'b0;
      fault        <= 1'b0;
      timeout_mask <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_req) begin
            state        <= SETTLE;
            idx          <= 2'd0;
            cnt          <= '0;
            busy         <= 1'b1;
            fault        <= 1'b0;
            timeout_mask <= 4'd0;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          // rdy on the timeout edge still captures real data
          if (sensor_rdy || (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            cap[idx] <= sensor_rdy ? sensor_data : 8'd0;
            if (!sensor_rdy) timeout_mask[idx] <= 1'b1;
            cnt <= '0;
            if (idx == 2'd3) begin
              state <= COMPUTE;
            end else begin
              idx   <= idx + 2'd1;
              state <= SETTLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMPUTE: begin
          height       <= height_next;
          fault        <= fault_next;
          height_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (height_ready) begin
            height_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_acquire.sv
// Self-checking bench for sensor_acquire: directed scenarios plus randomized
// runs scored against a functional model of the height/fault/latency rules.
module tb_sensor_acquire;

  localparam int SETTLE  = 3;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_req = 1'b0;
  logic [1:0] sensor_sel;
  logic [7:0] sensor_data;
  logic       sensor_rdy;
  logic       busy;
  logic [7:0] height;
  logic       height_valid;
  logic       height_ready = 1'b0;
  logic       fault;
  logic [3:0] timeout_mask;

  int checks   = 0;
  int failures = 0;

  // Mock sensor bus: per-sensor reading, "never ready" mask and an optional single rdy pulse
  logic [3:0][7:0] rd = '0;
  logic [3:0]      nev = '0;
  logic            race_on = 1'b0;
  int              race_edge = 0;
  int              ecount = 0;

  assign sensor_data = rd[sensor_sel];
  assign sensor_rdy  = !nev[sensor_sel] || (race_on && ecount == race_edge);

  // ecount equals n while waiting for edge n (edge 0 samples sample_req)
  always @(posedge clk) ecount <= sample_req ? 1 : ecount + 1;

  always #5 clk = ~clk;

  sensor_acquire #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_req(sample_req), .sensor_sel(sensor_sel),
    .sensor_data(sensor_data), .sensor_rdy(sensor_rdy), .busy(busy),
    .height(height), .height_valid(height_valid), .height_ready(height_ready),
    .fault(fault), .timeout_mask(timeout_mask)
  );

  // Functional reference: timed-out sensors read 0, then the pair rule on plain integers
  function automatic void model(input logic [3:0][7:0] v, input logic [3:0] nv,
                                output logic [7:0] h, output logic f, output int lat);
    int s[4];
    bit za, zb;
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      s[k] = nv[k] ? 0 : int'(v[k]);
      lat += SETTLE + (nv[k] ? TIMEOUT : 1);
    end
    za = (s[0] == 0) || (s[2] == 0);
    zb = (s[1] == 0) || (s[3] == 0);
    f = 1'b0;
    if (za && zb) begin
      f = 1'b1;
      h = 8'd0;
    end else if (za) h = 8'((s[1] + s[3] + 1) / 2);
    else if (zb)     h = 8'((s[0] + s[2] + 1) / 2);
    else             h = 8'((s[0] + s[1] + s[2] + s[3] + 2) / 4);
  endfunction

  // Starts a run and waits (bounded) for height_valid; lat = -1 if it never rises
  task automatic run_acq(input logic [3:0][7:0] v, input logic [3:0] nv,
                         input logic ron, input int redge,
                         output int lat, output logic [7:0] h, output logic f,
                         output logic [3:0] m);
    @(negedge clk);
    rd = v; nev = nv; race_on = ron; race_edge = redge;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (height_valid) begin
        lat = n;
        break;
      end
    end
    h = height; f = fault; m = timeout_mask;
  endtask

  task automatic accept();
    @(negedge clk);
    height_ready = 1'b1;
    @(posedge clk);
    #1 height_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sensor_sel, busy, height, height_valid, fault, timeout_mask} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%0d busy=%0b h=%0d v=%0b f=%0b m=%b, expected all 0",
               sensor_sel, busy, height, height_valid, fault, timeout_mask);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_double_fault();
    int lat; logic [7:0] h; logic f; logic [3:0] m;
    run_acq({8'd30, 8'd30, 8'd0, 8'd0}, 4'b0000, 1'b0, 0, lat, h, f, m);
    checks++;
    if (h !== 8'd0 || f !== 1'b1 || m !== 4'd0) begin
      failures++;
      $display("FAIL double_fault: got h=%0d f=%0b m=%b expected h=0 f=1 m=0000", h, f, m);
    end
    accept();
  endtask

  task automatic test_nominal();
    @(negedge clk);
    rd = {8'd104, 8'd98, 8'd102, 8'd100}; nev = 4'b0000; race_on = 1'b0;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || fault !== 1'b0 || timeout_mask !== 4'd0 || height !== 8'd0) begin
      failures++;
      $display("FAIL start_edge: got busy=%0b f=%0b m=%b h=%0d expected busy=1 f=0 m=0000 h=0 (kept)",
               busy, fault, timeout_mask, height);
    end
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      #1;
      if (n <= 15) begin
        checks++;
        if (sensor_sel !== 2'(n / 4)) begin
          failures++;
          $display("FAIL nominal_sel: edge %0d got %0d expected %0d", n, sensor_sel, n / 4);
        end
      end
      checks++;
      if (height_valid !== (n == 17)) begin
        failures++;
        $display("FAIL nominal_valid_timing: edge %0d got %0b expected %0b", n, height_valid, n == 17);
      end
    end
    checks++;
    if (height !== 8'd101 || fault !== 1'b0 || timeout_mask !== 4'd0) begin
      failures++;
      $display("FAIL nominal_result: got h=%0d f=%0b m=%b expected h=101 f=0 m=0000",
               height, fault, timeout_mask);
    end
    accept();
  endtask

  task automatic test_pairs();
    int lat; logic [7:0] h; logic f; logic [3:0] m;
    run_acq({8'd51, 8'd90, 8'd50, 8'd0}, 4'b0000, 1'b0, 0, lat, h, f, m);
    checks++;
    if (h !== 8'd51 || f !== 1'b0 || lat !== 17) begin
      failures++;
      $display("FAIL zero_pair_a: got h=%0d f=%0b lat=%0d expected h=51 f=0 lat=17", h, f, lat);
    end
    accept();
    run_acq({8'd200, 8'd41, 8'd0, 8'd40}, 4'b0000, 1'b0, 0, lat, h, f, m);
    checks++;
    if (h !== 8'd41 || f !== 1'b0) begin
      failures++;
      $display("FAIL zero_pair_b: got h=%0d f=%0b expected h=41 f=0", h, f);
    end
    accept();
  endtask

  // Timeout on sensor 3 and the handshake hold/ignore behaviour while in DONE
  task automatic test_timeout_handshake();
    int lat; logic [7:0] h; logic f; logic [3:0] m;
    run_acq({8'd60, 8'd60, 8'd60, 8'd60}, 4'b0100, 1'b0, 0, lat, h, f, m);
    checks++;
    if (h !== 8'd60 || f !== 1'b0 || m !== 4'b0100 || lat !== 17 + TIMEOUT - 1) begin
      failures++;
      $display("FAIL timeout: got h=%0d f=%0b m=%b lat=%0d expected h=60 f=0 m=0100 lat=%0d",
               h, f, m, lat, 17 + TIMEOUT - 1);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sample_req = (c == 4);
      @(posedge clk);
      #1 sample_req = 1'b0;
      checks++;
      if (height_valid !== 1'b1 || height !== 8'd60 || timeout_mask !== 4'b0100 || busy !== 1'b1) begin
        failures++;
        $display("FAIL done_hold: cycle %0d got v=%0b h=%0d m=%b busy=%0b expected v=1 h=60 m=0100 busy=1",
                 c, height_valid, height, timeout_mask, busy);
      end
    end
    @(negedge clk);
    height_ready = 1'b1; sample_req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (height_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accept_edge: got v=%0b busy=%0b expected v=0 busy=0", height_valid, busy);
    end
    @(negedge clk);
    height_ready = 1'b0; sample_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || height !== 8'd60) begin
      failures++;
      $display("FAIL req_not_queued: got busy=%0b h=%0d expected busy=0 h=60", busy, height);
    end
  endtask

  task automatic test_race();
    int lat; logic [7:0] h; logic f; logic [3:0] m;
    // sensor 3 WAIT starts after edge 11; its timeout edge is 11 + TIMEOUT
    run_acq({8'd60, 8'd77, 8'd60, 8'd60}, 4'b0100, 1'b1, 2 * (SETTLE + 1) + SETTLE + TIMEOUT,
            lat, h, f, m);
    checks++;
    if (h !== 8'd64 || m !== 4'b0000 || f !== 1'b0 || lat !== 17 + TIMEOUT - 1) begin
      failures++;
      $display("FAIL race_capture: got h=%0d m=%b f=%0b lat=%0d expected h=64 m=0000 f=0 lat=%0d",
               h, m, f, lat, 17 + TIMEOUT - 1);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] h; logic f; logic [3:0] m;
    @(negedge clk);
    rd = {8'd104, 8'd98, 8'd102, 8'd100}; nev = 4'b0010; race_on = 1'b0;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({sensor_sel, busy, height, height_valid, fault, timeout_mask} !== 17'd0) begin
      failures++;
      $display("FAIL reset_mid: got sel=%0d busy=%0b h=%0d v=%0b f=%0b m=%b expected all 0",
               sensor_sel, busy, height, height_valid, fault, timeout_mask);
    end
    @(negedge clk) rst = 1'b0;
    run_acq({8'd104, 8'd98, 8'd102, 8'd100}, 4'b0000, 1'b0, 0, lat, h, f, m);
    checks++;
    if (h !== 8'd101 || f !== 1'b0 || m !== 4'd0 || lat !== 17) begin
      failures++;
      $display("FAIL after_reset_run: got h=%0d f=%0b m=%b lat=%0d expected h=101 f=0 m=0000 lat=17",
               h, f, m, lat);
    end
    accept();
  endtask

  task automatic test_random();
    int lat, elat; logic [7:0] h, eh; logic f, ef; logic [3:0] m;
    logic [3:0][7:0] v; logic [3:0] nv;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 4; k++) begin
        v[k]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        nv[k] = ($urandom_range(0, 5) == 0);
      end
      model(v, nv, eh, ef, elat);
      run_acq(v, nv, 1'b0, 0, lat, h, f, m);
      checks++;
      if (h !== eh || f !== ef || m !== nv || lat !== elat) begin
        failures++;
        $display("FAIL random_run: it %0d v=%h nv=%b got h=%0d f=%0b m=%b lat=%0d expected h=%0d f=%0b m=%b lat=%0d",
                 it, v, nv, h, f, m, lat, eh, ef, nv, elat);
      end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_double_fault();
    test_nominal();
    test_pairs();
    test_timeout_handshake();
    test_race();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
